// File: rtl/fft_seq_pkg.sv
// Purpose: shared types and defaults for the FFT job sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft_seq_pkg;

    localparam int FSQ_BIT_WIDTH = 16;
    localparam int FSQ_N_POINTS  = 64;

    // Job mode as carried in bits [1:0] of the command word.
    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_FFT  = 2'b01,
        MODE_IFFT = 2'b10,
        MODE_FIR  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECEIVE = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SEND    = 3'd4
    } state_e;

    // A command word only starts a job when it names a real mode.
    function automatic logic is_job_cmd(input logic [1:0] mode_bits);
        return mode_bits != MODE_IDLE;
    endfunction

endpackage

// File: rtl/fft_job_sequencer_if.sv
// Purpose: pad stream, engine handshake and buffer ports of the job sequencer.
// Latency: n/a (wiring only).
// Backpressure: o_ready on the input stream; the output stream has none.
interface fft_job_sequencer_if #(
    parameter int BIT_WIDTH = 16,
    parameter int ADDR_W    = 6
);
    logic [BIT_WIDTH-1:0] i_data;
    logic                 i_valid;
    logic                 o_ready;
    logic [1:0]           o_eng_mode;
    logic                 o_eng_start;
    logic                 i_eng_done;
    logic                 o_wr_en;
    logic [ADDR_W-1:0]    o_wr_addr;
    logic [BIT_WIDTH-1:0] o_wr_data;
    logic                 o_rd_en;
    logic [ADDR_W-1:0]    o_rd_addr;
    logic [BIT_WIDTH-1:0] i_rd_data;
    logic [BIT_WIDTH-1:0] o_data;
    logic                 o_valid;
    logic                 o_start_bit;
    logic                 o_busy;
    logic                 o_error;

    // Sequencer side.
    modport slave (
        input  i_data, i_valid, i_eng_done, i_rd_data,
        output o_ready, o_eng_mode, o_eng_start, o_wr_en, o_wr_addr, o_wr_data,
               o_rd_en, o_rd_addr, o_data, o_valid, o_start_bit, o_busy, o_error
    );

    // Pad / engine / buffer side.
    modport master (
        output i_data, i_valid, i_eng_done, i_rd_data,
        input  o_ready, o_eng_mode, o_eng_start, o_wr_en, o_wr_addr, o_wr_data,
               o_rd_en, o_rd_addr, o_data, o_valid, o_start_bit, o_busy, o_error
    );
endinterface

// File: rtl/fft_seq_watchdog.sv
// Purpose: counts WAIT cycles and flags expiry at TIMEOUT_CYC-1.
// Latency: expire_o is combinational from the registered count.
// Backpressure: none; load_i restarts the count at 0.
module fft_seq_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic i_clk,
    input  logic i_rstb,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    // Reload on the cycle before WAIT, then count once per WAIT cycle and hold at expiry.
    always_ff @(posedge i_clk) begin
        if (i_rstb) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (count_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/fft_job_sequencer.sv
// Purpose: sequences one job: command, N_POINTS sample writes, engine start/done, N_POINTS result reads. Watchdog under FFT_SEQ_TIMEOUT_EN.
// Latency: start pulse 1 cycle after last sample; reads begin 1 cycle after done, o_valid 1 cycle after each read.
// Backpressure: o_ready high only in IDLE/RECEIVE; the result stream cannot be stalled.
module fft_job_sequencer
    import fft_seq_pkg::*;
#(
    parameter int BIT_WIDTH   = FSQ_BIT_WIDTH,
    parameter int N_POINTS    = FSQ_N_POINTS,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               i_clk,
    input  logic               i_rstb,
    fft_job_sequencer_if.slave bus
);
    localparam int AW = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_POINTS - 1);

    state_e         state_q;
    logic [AW-1:0]  cnt_q;
    mode_e          mode_q;
    logic           start_q;
    logic           valid_q;
    logic [AW-1:0]  rd_addr_q;

    logic                 ready_d;
    logic                 accept_d;
    logic                 wr_en_d;
    logic [AW-1:0]        wr_addr_d;
    logic [BIT_WIDTH-1:0] wr_data_d;
    logic                 rd_en_d;
    logic [AW-1:0]        rd_addr_d;
    logic                 last_d;

`ifdef FFT_SEQ_TIMEOUT_EN
    logic error_q;
    logic wd_expire;

    fft_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rstb   (i_rstb),
        .load_i   (state_q == ST_START),
        .count_i  (state_q == ST_WAIT),
        .expire_o (wd_expire)
    );

    assign bus.o_error = error_q;
`else
    assign bus.o_error = 1'b0;
`endif

    // Stream accept, sample-buffer write and result-buffer read strobes for the current state.
    always_comb begin
        ready_d   = (state_q == ST_IDLE) || (state_q == ST_RECEIVE);
        accept_d  = bus.i_valid && ready_d;
        wr_en_d   = accept_d && (state_q == ST_RECEIVE);
        wr_addr_d = wr_en_d ? cnt_q : '0;
        wr_data_d = wr_en_d ? bus.i_data : '0;
        rd_en_d   = (state_q == ST_SEND);
        rd_addr_d = rd_en_d ? cnt_q : '0;
        last_d    = (cnt_q == LAST_ADDR);
    end

    // Job FSM with its registered outputs; the state change, not the counter wrap, ends each phase.
    always_ff @(posedge i_clk) begin
        if (i_rstb) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= MODE_IDLE;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            rd_addr_q <= '0;
`ifdef FFT_SEQ_TIMEOUT_EN
            error_q   <= 1'b0;
`endif
        end else begin
            valid_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            start_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d && is_job_cmd(bus.i_data[1:0])) begin
                        mode_q  <= mode_e'(bus.i_data[1:0]);
                        cnt_q   <= '0;
                        state_q <= ST_RECEIVE;
`ifdef FFT_SEQ_TIMEOUT_EN
                        error_q <= 1'b0;
`endif
                    end
                end
                ST_RECEIVE: begin
                    if (accept_d) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_d) begin
                            state_q <= ST_START;
                            start_q <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.i_eng_done) begin
                        cnt_q   <= '0;
                        state_q <= ST_SEND;
                    end
`ifdef FFT_SEQ_TIMEOUT_EN
                    else if (wd_expire) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
`endif
                end
                ST_SEND: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_d) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready     = ready_d;
    assign bus.o_eng_mode  = mode_q;
    assign bus.o_eng_start = start_q;
    assign bus.o_wr_en     = wr_en_d;
    assign bus.o_wr_addr   = wr_addr_d;
    assign bus.o_wr_data   = wr_data_d;
    assign bus.o_rd_en     = rd_en_d;
    assign bus.o_rd_addr   = rd_addr_d;
    assign bus.o_data      = bus.i_rd_data;
    assign bus.o_valid     = valid_q;
    assign bus.o_start_bit = valid_q && (rd_addr_q == '0);
    assign bus.o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fft_job_sequencer.sv
// Purpose: self-checking bench for fft_job_sequencer (write and read scoreboards).
// Latency: inputs driven 1ns after posedge, outputs sampled at negedge.
// Backpressure: bench only offers words; engine and buffer are modelled here.
module tb_fft_job_sequencer;
    import fft_seq_pkg::*;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    logic clk  = 1'b0;
    logic rstb = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [21:0] wq[$];
    logic [15:0] oq[$];

    always #5 clk = ~clk;

    fft_job_sequencer_if #(.BIT_WIDTH(16), .ADDR_W(6)) bus ();

    fft_job_sequencer #(
        .BIT_WIDTH   (16),
        .N_POINTS    (64),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk  (clk),
        .i_rstb (rstb),
        .bus    (bus)
    );

    // Result buffer model: one-cycle read latency, data = addr + 0x5000.
    always @(posedge clk)
        bus.i_rd_data <= bus.o_rd_en ? (16'h5000 + {10'd0, bus.o_rd_addr}) : 16'hDEAD;

    task automatic step(input logic v, input logic [15:0] d, input logic done);
        @(posedge clk);
        #1;
        bus.i_valid    = v;
        bus.i_data     = d;
        bus.i_eng_done = done;
        @(negedge clk);
    endtask

    task automatic finish_job();
        step(1'b0, 16'h0, 1'b1);
        repeat (70) step(1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_reset();
        rstb = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        rstb = 1'b0;
        total++;
        if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
        total++;
        if ({bus.o_busy, bus.o_eng_start, bus.o_wr_en, bus.o_rd_en, bus.o_valid, bus.o_start_bit, bus.o_error} !== 7'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000000",
                {bus.o_busy, bus.o_eng_start, bus.o_wr_en, bus.o_rd_en, bus.o_valid, bus.o_start_bit, bus.o_error});
        end
        total++;
        if (bus.o_eng_mode !== 2'b00) begin bad++; $display("FAIL reset_mode: got %b want 00", bus.o_eng_mode); end
    endtask

    task automatic test_fft_continuous();
        int nwr = 0;
        int early = 0;
        logic [21:0] exp;
        step(1'b1, 16'h0001, 1'b0);
        total++;
        if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL fft_cmd_ready: got %b want 1", bus.o_ready); end
        for (int i = 0; i < 64; i++) begin
            wq.push_back({6'(i), 16'h0100 + 16'(i)});
            step(1'b1, 16'h0100 + 16'(i), 1'b0);
            if (bus.o_eng_start) early++;
            if (bus.o_wr_en) begin
                nwr++;
                exp = (wq.size() != 0) ? wq.pop_front() : 22'h3FFFFF;
                total++;
                if ({bus.o_wr_addr, bus.o_wr_data} !== exp) begin
                    bad++; $display("FAIL fft_write: got %h/%h want %h/%h", bus.o_wr_addr, bus.o_wr_data, exp[21:16], exp[15:0]);
                end
            end
        end
        total++;
        if (nwr != 64 || early != 0) begin bad++; $display("FAIL fft_write_count: got %0d writes %0d early starts want 64/0", nwr, early); end
        step(1'b0, 16'h0, 1'b0);
        total++;
        if (bus.o_eng_start !== 1'b1) begin bad++; $display("FAIL fft_start_c65: got %b want 1", bus.o_eng_start); end
        total++;
        if (bus.o_eng_mode !== 2'b01 || bus.o_ready !== 1'b0) begin
            bad++; $display("FAIL fft_mode_ready: got %b/%b want 01/0", bus.o_eng_mode, bus.o_ready);
        end
        step(1'b0, 16'h0, 1'b0);
        total++;
        if (bus.o_eng_start !== 1'b0) begin bad++; $display("FAIL fft_start_once: got %b want 0", bus.o_eng_start); end
        finish_job();
        wq.delete();
    endtask

    task automatic test_ifft_gappy();
        int nwr = 0;
        int early = 0;
        logic [21:0] exp;
        step(1'b1, 16'h0002, 1'b0);
        for (int k = 0; k < 127; k++) begin
            if (k % 2 == 0) begin
                wq.push_back({6'(k / 2), 16'h0200 + 16'(k / 2)});
                step(1'b1, 16'h0200 + 16'(k / 2), 1'b0);
            end else begin
                step(1'b0, 16'hBEEF, 1'b0);
            end
            if (bus.o_eng_start) early++;
            if (bus.o_wr_en) begin
                nwr++;
                exp = (wq.size() != 0) ? wq.pop_front() : 22'h3FFFFF;
                total++;
                if ({bus.o_wr_addr, bus.o_wr_data} !== exp) begin
                    bad++; $display("FAIL ifft_write: got %h/%h want %h/%h", bus.o_wr_addr, bus.o_wr_data, exp[21:16], exp[15:0]);
                end
            end
        end
        total++;
        if (nwr != 64 || early != 0) begin bad++; $display("FAIL ifft_write_count: got %0d writes %0d early starts want 64/0", nwr, early); end
        step(1'b0, 16'h0, 1'b0);
        total++;
        if (bus.o_eng_start !== 1'b1 || bus.o_eng_mode !== 2'b10) begin
            bad++; $display("FAIL ifft_start_mode: got %b/%b want 1/10", bus.o_eng_start, bus.o_eng_mode);
        end
        finish_job();
        wq.delete();
    endtask

    task automatic test_fir_send();
        int nwr = 0;
        int stray = 0;
        logic [15:0] exp;
        step(1'b1, 16'hFFFF, 1'b0);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 16'h0300 + 16'(i), 1'b0);
            if (bus.o_wr_en) nwr++;
        end
        step(1'b0, 16'h0, 1'b0);
        total++;
        if (nwr != 64 || bus.o_eng_start !== 1'b1) begin bad++; $display("FAIL fir_load: got %0d writes start %b want 64/1", nwr, bus.o_eng_start); end
        repeat (10) begin
            step(1'b0, 16'h0, 1'b0);
            if (!bus.o_busy || bus.o_rd_en || bus.o_valid) stray++;
        end
        total++;
        if (stray != 0 || bus.o_eng_mode !== 2'b11) begin bad++; $display("FAIL fir_wait: got %0d bad cycles mode %b want 0/11", stray, bus.o_eng_mode); end
        for (int i = 0; i < 64; i++) oq.push_back(16'h5000 + 16'(i));
        step(1'b0, 16'h0, 1'b1);
        for (int r = 1; r <= 66; r++) begin
            step(1'b0, 16'h0, 1'b0);
            total++;
            if (bus.o_rd_en !== (r <= 64) || (bus.o_rd_en && bus.o_rd_addr !== 6'(r - 1))) begin
                bad++; $display("FAIL fir_rd d+%0d: got en=%b addr=%0d want en=%b addr=%0d", r, bus.o_rd_en, bus.o_rd_addr, (r <= 64), r - 1);
            end
            total++;
            if (bus.o_valid !== (r >= 2 && r <= 65)) begin
                bad++; $display("FAIL fir_valid d+%0d: got %b want %b", r, bus.o_valid, (r >= 2 && r <= 65));
            end
            total++;
            if (bus.o_start_bit !== (r == 2)) begin
                bad++; $display("FAIL fir_start_bit d+%0d: got %b want %b", r, bus.o_start_bit, (r == 2));
            end
            if (bus.o_valid === 1'b1) begin
                exp = (oq.size() != 0) ? oq.pop_front() : 16'hFFFF;
                total++;
                if (bus.o_data !== exp) begin bad++; $display("FAIL fir_data d+%0d: got %h want %h", r, bus.o_data, exp); end
            end
            if (r == 65) begin
                total++;
                if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
                    bad++; $display("FAIL fir_idle_d65: got ready=%b busy=%b want 1/0", bus.o_ready, bus.o_busy);
                end
            end
        end
        total++;
        if (oq.size() != 0) begin bad++; $display("FAIL fir_out_count: got %0d left want 0", oq.size()); end
        oq.delete();
    endtask

    task automatic test_idle_ignore();
        int stray = 0;
        step(1'b1, 16'h0000, 1'b0);
        if (bus.o_wr_en || bus.o_eng_start || bus.o_busy || bus.o_rd_en) stray++;
        step(1'b1, 16'hFFFC, 1'b0);
        if (bus.o_wr_en || bus.o_eng_start || bus.o_busy || bus.o_rd_en) stray++;
        step(1'b0, 16'h0, 1'b1);
        repeat (4) begin
            step(1'b0, 16'h0, 1'b0);
            if (bus.o_wr_en || bus.o_eng_start || bus.o_busy || bus.o_rd_en || bus.o_valid) stray++;
        end
        total++;
        if (stray != 0) begin bad++; $display("FAIL idle_ignore: got %0d active cycles want 0", stray); end
        total++;
        if (bus.o_eng_mode !== 2'b11) begin bad++; $display("FAIL idle_mode_hold: got %b want 11", bus.o_eng_mode); end
    endtask

    task automatic test_reset_mid_job();
        int nwr = 0;
        logic [21:0] exp;
        step(1'b1, 16'h0001, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 16'h011E;
        @(negedge clk);
        @(posedge clk);
        #1;
        rstb = 1'b0;
        bus.i_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.o_busy, bus.o_eng_start, bus.o_wr_en, bus.o_rd_en, bus.o_valid, bus.o_start_bit, bus.o_error, bus.o_eng_mode} !== 9'b0
            || bus.o_wr_addr !== 6'd0 || bus.o_rd_addr !== 6'd0) begin
            bad++; $display("FAIL midreset_outputs: got busy=%b start=%b wr=%b rd=%b v=%b sb=%b err=%b mode=%b want all 0",
                bus.o_busy, bus.o_eng_start, bus.o_wr_en, bus.o_rd_en, bus.o_valid, bus.o_start_bit, bus.o_error, bus.o_eng_mode);
        end
        step(1'b1, 16'h0003, 1'b0);
        for (int i = 0; i < 64; i++) begin
            wq.push_back({6'(i), 16'h0700 + 16'(i)});
            step(1'b1, 16'h0700 + 16'(i), 1'b0);
            if (bus.o_wr_en) begin
                nwr++;
                exp = (wq.size() != 0) ? wq.pop_front() : 22'h3FFFFF;
                total++;
                if ({bus.o_wr_addr, bus.o_wr_data} !== exp) begin
                    bad++; $display("FAIL fresh_write: got %h/%h want %h/%h", bus.o_wr_addr, bus.o_wr_data, exp[21:16], exp[15:0]);
                end
            end
        end
        step(1'b0, 16'h0, 1'b0);
        total++;
        if (nwr != 64 || bus.o_eng_start !== 1'b1) begin bad++; $display("FAIL fresh_job: got %0d writes start %b want 64/1", nwr, bus.o_eng_start); end
        finish_job();
        wq.delete();
    endtask

`ifdef FFT_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        step(1'b1, 16'h0001, 1'b0);
        for (int i = 0; i < 64; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0);
        step(1'b0, 16'h0, 1'b0);
        for (int w = 1; w <= 16; w++) step(1'b0, 16'h0, 1'b0);
        total++;
        if (bus.o_busy !== 1'b1 || bus.o_error !== 1'b0) begin
            bad++; $display("FAIL to_last_wait: got busy=%b err=%b want 1/0", bus.o_busy, bus.o_error);
        end
        step(1'b0, 16'h0, 1'b0);
        total++;
        if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b0) begin
            bad++; $display("FAIL to_expired: got err=%b busy=%b want 1/0", bus.o_error, bus.o_busy);
        end
        step(1'b1, 16'h0002, 1'b0);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 16'h0200 + 16'(i), 1'b0);
            if (i == 0) begin
                total++;
                if (bus.o_error !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", bus.o_error); end
            end
        end
        step(1'b0, 16'h0, 1'b0);
        for (int w = 1; w <= 15; w++) step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0);
        total++;
        if (bus.o_busy !== 1'b1 || bus.o_rd_en !== 1'b1 || bus.o_error !== 1'b0) begin
            bad++; $display("FAIL to_done_wins: got busy=%b rd=%b err=%b want 1/1/0", bus.o_busy, bus.o_rd_en, bus.o_error);
        end
        repeat (70) step(1'b0, 16'h0, 1'b0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.i_valid    = 1'b0;
        bus.i_data     = 16'h0;
        bus.i_eng_done = 1'b0;
        test_reset();
        test_fft_continuous();
        test_ifft_gappy();
        test_fir_send();
        test_idle_ignore();
        test_reset_mid_job();
`ifdef FFT_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
